mux_nx1_pipe: RTL and testbench
===============================

# mux_nx1_pipe

- Parametrised, pipelined N:1 multiplexer built as a binary tree of W-bit 2:1 mux cells.
- Successor to the fixed 4:1 single-bit tree: generalised in input count and data width.
- Adds one register stage per tree level and a valid/ready handshake with backpressure.
- Used wherever a wide operand must be selected from many sources at full clock rate.

## Interface
- N_IN, 8, number of data inputs; legal 2..64, need not be a power of two
- W, 8, data width per input in bits; legal 1..64
- SEL_W (localparam), clog2(N_IN), select width; also the number of tree levels and pipeline stages
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  N_IN*W  flattened inputs; input i occupies bits [i*W +: W]
- in_sel  input  SEL_W  index of the input to forward
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts output beat
- out_data  output  W  selected input data
- out_sel  output  SEL_W  in_sel value that produced out_data
- sel_err  output  1  beat was launched with in_sel >= N_IN (see Configuration)

## Operation
- Tree of SEL_W levels. Level k (k = 0 first) resolves pairs with select bit k, LSB first: level 0 pairs (0,1), (2,3) and so on; the last level produces a single word.
- Non-power-of-two N_IN: missing leaves of the 2^SEL_W tree are constant zero.
- Each level's outputs are registered together with the remaining select bits, out_sel and a valid bit.
- Input capture: a beat is captured when in_valid && in_ready; in_data and in_sel are sampled in that cycle only.
- Advance rule: adv = !out_valid || out_ready. When adv = 1, every stage shifts one level; the stage-0 valid loads in_valid && in_ready.
- in_ready = adv, purely combinational from out_valid and out_ready.
- When adv = 0, every stage holds, including data, select and valid.
- Bubbles are not collapsed: an empty stage still shifts in lockstep.
- Beats leave in order; none is dropped or duplicated.
- out_data, out_sel and sel_err stay stable while out_valid && !out_ready.
- Reset mid-stream: all in-flight beats are discarded and no partial output is emitted.

## Timing
- Latency: SEL_W cycles from the capture edge to out_valid, with no stalls. Examples: N_IN = 8 gives 3 cycles; N_IN = 2 gives 1 cycle.
- Throughput: one beat per cycle while out_ready = 1.
- Each stall cycle adds exactly one cycle to the latency of every in-flight beat.
- Reset values, applied on the clk edge while rst_n = 0:
  - out_valid = 0, out_data = 0, out_sel = 0, sel_err = 0
  - all stage valid, data and select registers = 0
- in_ready = 1 during and after reset, because out_valid = 0.
- Simultaneous out_ready = 1 and in_valid = 1 on a full pipe: the output retires and the input is captured in the same cycle.
- Select changes between beats take effect per beat; there is no cross-beat interaction.

## Configuration
- Macro: MUX_NX1_PIPE_SEL_CHECK_EN.
- Defined:
  - in_sel >= N_IN is detected at capture.
  - A flag travels with the beat and sel_err = 1 with that output beat.
  - out_data = 0 for that beat.
- Undefined:
  - No check logic is built and sel_err is tied to 0.
  - An out-of-range select still yields out_data = 0 through the zero leaves, but this is not flagged.
- Power-of-two N_IN with the macro defined: sel_err is constant 0.

## Structure
- Shared package mux_pkg holds:
  - clog2 function
  - N_IN_MAX = 64 and W_MAX = 64
  - pipeline-stage record typedef {valid, sel_rem, sel_orig, err}
- Sub-module mux_2x1_w: W-bit 2:1 combinational cell (I0, I1, S0, Y).
- The top instantiates mux_2x1_w cells per level with a generate loop and owns all registers.

## Test plan
- N_IN = 8, W = 8, inputs i = 0x10+i, out_ready = 1, in_sel = 5 at cycle 0 -> out_valid at cycle 3 with out_data = 0x15, out_sel = 5.
- Back-to-back sweep of in_sel 0..7 over 8 cycles -> outputs 0x10..0x17 in order on cycles 3..10 with no gaps.
- Backpressure: out_ready = 0 for 4 cycles with the pipe full -> in_ready = 0, outputs held stable; on release, all beats drain in order with none lost.
- N_IN = 5, macro defined, in_sel = 6 -> out_data = 0, sel_err = 1; in_sel = 4 -> data of input 4 with sel_err = 0.
- rst_n = 0 for one cycle with 3 beats in flight -> out_valid = 0 on the next cycle, those beats never appear, in_ready = 1.
- N_IN = 2, W = 1 -> latency 1 cycle; in_sel = 1 forwards input 1.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined N:1 multiplexer tree.
// Stage records are sized for the largest legal configuration.
package mux_pkg;

   localparam int unsigned N_IN_MAX  = 64;
   localparam int unsigned W_MAX     = 64;
   localparam int unsigned SEL_W_MAX = 6;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r++;
      end
      return r;
   endfunction

   typedef struct packed {
      logic                 valid;
      logic [SEL_W_MAX-1:0] sel_rem;
      logic [SEL_W_MAX-1:0] sel_orig;
      logic                 err;
   } stage_t;

endpackage

// File: rtl/mux_2x1_w.sv
// W-bit 2:1 combinational mux cell used at every node of the selection tree.
module mux_2x1_w #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] i0_i,
   input  logic [W-1:0] i1_i,
   input  logic         s0_i,
   output logic [W-1:0] y_o
);

   assign y_o = s0_i ? i1_i : i0_i;

endmodule

// File: rtl/mux_nx1_pipe.sv
// Pipelined N:1 mux tree, one register stage per level, valid/ready with backpressure.
// Optional out-of-range select flagging is built when MUX_NX1_PIPE_SEL_CHECK_EN is defined.
module mux_nx1_pipe
   import mux_pkg::*;
#(
   parameter int unsigned N_IN = 8,
   parameter int unsigned W    = 8,
   localparam int unsigned SEL_W = clog2(N_IN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN*W-1:0] in_data,
   input  logic [SEL_W-1:0]  in_sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_sel,
   output logic              sel_err
);

   localparam int unsigned Leaves = 1 << SEL_W;

   logic                  adv;
   logic                  sel_oor;
   logic [Leaves-1:0][W-1:0] leaves;

   // The whole pipe moves in lockstep whenever the output slot is free or retiring.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_comb begin
      leaves = '0;
      for (int i = 0; i < N_IN; i++) begin
         leaves[i] = in_data[i*W +: W];
      end
   end

`ifdef MUX_NX1_PIPE_SEL_CHECK_EN
   assign sel_oor = 32'(in_sel) >= N_IN;
`else
   assign sel_oor = 1'b0;
`endif

   for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
      localparam int unsigned NOut = Leaves >> (k + 1);

      logic [2*NOut-1:0][W-1:0] lvl_in;
      logic [NOut-1:0][W-1:0]   mux_out;
      logic [NOut-1:0][W-1:0]   data_q;
      stage_t                   src;
      stage_t                   st_d;
      stage_t                   st_q;

      if (k == 0) begin : g_head
         assign lvl_in = leaves;
         always_comb begin
            src          = '0;
            src.valid    = in_valid && adv;
            src.sel_rem  = SEL_W_MAX'(in_sel);
            src.sel_orig = SEL_W_MAX'(in_sel);
            src.err      = sel_oor;
         end
      end else begin : g_body
         assign lvl_in = g_lvl[k-1].data_q;
         assign src    = g_lvl[k-1].st_q;
      end

      for (genvar j = 0; j < NOut; j++) begin : g_cell
         mux_2x1_w #(
            .W(W)
         ) u_cell (
            .i0_i(lvl_in[2*j]),
            .i1_i(lvl_in[2*j+1]),
            .s0_i(src.sel_rem[0]),
            .y_o (mux_out[j])
         );
      end

      // Each level consumes the LSB of the remaining select.
      always_comb begin
         st_d         = src;
         st_d.sel_rem = src.sel_rem >> 1;
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            st_q   <= '0;
            data_q <= '0;
         end else if (adv) begin
            st_q   <= st_d;
            data_q <= mux_out;
         end
      end
   end

   logic unused_last;
   assign unused_last = ^g_lvl[SEL_W-1].st_q;

   assign out_valid = g_lvl[SEL_W-1].st_q.valid;
   assign out_sel   = g_lvl[SEL_W-1].st_q.sel_orig[SEL_W-1:0];

`ifdef MUX_NX1_PIPE_SEL_CHECK_EN
   assign sel_err  = g_lvl[SEL_W-1].st_q.err;
   assign out_data = g_lvl[SEL_W-1].st_q.err ? '0 : g_lvl[SEL_W-1].data_q[0];
`else
   assign sel_err  = 1'b0;
   assign out_data = g_lvl[SEL_W-1].data_q[0];
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed self-checking bench: 8:1 x8, 5:1 x8 and 2:1 x1 instances of mux_nx1_pipe.
module tb_mux_nx1_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // 8:1, W = 8
   logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_sel_err;
   logic [63:0] a_in_data;
   logic [2:0]  a_in_sel = '0, a_out_sel;
   logic [7:0]  a_out_data;
   // 5:1, W = 8
   logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_sel_err;
   logic [39:0] b_in_data;
   logic [2:0]  b_in_sel = '0, b_out_sel;
   logic [7:0]  b_out_data;
   // 2:1, W = 1
   logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_sel_err;
   logic [1:0]  c_in_data = 2'b10;
   logic [0:0]  c_in_sel = '0, c_out_sel;
   logic [0:0]  c_out_data;

   initial begin
      for (int i = 0; i < 8; i++) a_in_data[i*8 +: 8] = 8'h10 + 8'(i);
      for (int i = 0; i < 5; i++) b_in_data[i*8 +: 8] = 8'h20 + 8'(i);
   end

   mux_nx1_pipe #(.N_IN(8), .W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_sel(a_in_sel), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_data(a_out_data), .out_sel(a_out_sel),
      .sel_err(a_sel_err)
   );

   mux_nx1_pipe #(.N_IN(5), .W(8)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_sel(b_in_sel), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .out_sel(b_out_sel),
      .sel_err(b_sel_err)
   );

   mux_nx1_pipe #(.N_IN(2), .W(1)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .in_sel(c_in_sel), .out_valid(c_out_valid),
      .out_ready(c_out_ready), .out_data(c_out_data), .out_sel(c_out_sel),
      .sel_err(c_sel_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({a_out_valid, a_out_data, a_out_sel, a_sel_err} !== 13'h0) begin
         errors++;
         $display("FAIL reset_a: got v=%0b d=%0h s=%0d e=%0b want all 0",
                  a_out_valid, a_out_data, a_out_sel, a_sel_err);
      end
      checks++;
      if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 111", {a_in_ready, b_in_ready, c_in_ready});
      end
      checks++;
      if ({b_out_valid, b_sel_err, c_out_valid, c_out_data} !== 4'b0) begin
         errors++;
         $display("FAIL reset_bc: got %b want 0000",
                  {b_out_valid, b_sel_err, c_out_valid, c_out_data});
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_latency();
      int lat;
      a_in_valid = 1'b1;
      a_in_sel   = 3'd5;
      step();
      a_in_valid = 1'b0;
      lat = 1;
      while (!a_out_valid && lat < 10) begin
         step();
         lat++;
      end
      checks++;
      if (!a_out_valid || lat != 3) begin
         errors++;
         $display("FAIL latency: got %0d cycles (valid=%0b) want 3", lat, a_out_valid);
      end
      checks++;
      if (a_out_data !== 8'h15 || a_out_sel !== 3'd5) begin
         errors++;
         $display("FAIL latency_data: got d=%0h s=%0d want d=15 s=5", a_out_data, a_out_sel);
      end
      step();
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_single: got out_valid=%0b want 0", a_out_valid);
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 11; t++) begin
         a_in_valid = (t < 8);
         a_in_sel   = 3'(t);
         step();
         if (t >= 2 && t <= 9) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 8'h10 + 8'(t - 2) ||
                a_out_sel !== 3'(t - 2)) begin
               errors++;
               $display("FAIL b2b[%0d]: got v=%0b d=%0h s=%0d want v=1 d=%0h s=%0d", t,
                        a_out_valid, a_out_data, a_out_sel, 8'h10 + 8'(t - 2), t - 2);
            end
         end else begin
            checks++;
            if (a_out_valid !== 1'b0) begin
               errors++;
               $display("FAIL b2b_idle[%0d]: got out_valid=%0b want 0", t, a_out_valid);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_d [4];
      exp_d = '{8'h10, 8'h11, 8'h12, 8'h13};
      for (int t = 0; t < 3; t++) begin
         a_in_valid = 1'b1;
         a_in_sel   = 3'(t);
         step();
      end
      a_out_ready = 1'b0;
      a_in_sel    = 3'd3;
      #1;
      checks++;
      if (a_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_in_ready: got %0b want 0", a_in_ready);
      end
      for (int t = 0; t < 4; t++) begin
         step();
         checks++;
         if (a_out_valid !== 1'b1 || a_out_data !== 8'h10 || a_out_sel !== 3'd0 ||
             a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got v=%0b d=%0h s=%0d rdy=%0b want v=1 d=10 s=0 rdy=0",
                     t, a_out_valid, a_out_data, a_out_sel, a_in_ready);
         end
      end
      a_out_ready = 1'b1;
      for (int t = 1; t < 4; t++) begin
         step();
         a_in_valid = 1'b0;
         checks++;
         if (a_out_valid !== 1'b1 || a_out_data !== exp_d[t]) begin
            errors++;
            $display("FAIL bp_drain[%0d]: got v=%0b d=%0h want v=1 d=%0h", t, a_out_valid,
                     a_out_data, exp_d[t]);
         end
      end
      step();
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty: got out_valid=%0b want 0", a_out_valid);
      end
   endtask

   task automatic test_sel_check();
      logic exp_err;
`ifdef MUX_NX1_PIPE_SEL_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      b_in_valid = 1'b1;
      b_in_sel   = 3'd6;
      step();
      b_in_sel   = 3'd4;
      step();
      b_in_valid = 1'b0;
      step();
      checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== 8'h00 || b_sel_err !== exp_err ||
          b_out_sel !== 3'd6) begin
         errors++;
         $display("FAIL sel_oor: got v=%0b d=%0h e=%0b s=%0d want v=1 d=0 e=%0b s=6",
                  b_out_valid, b_out_data, b_sel_err, b_out_sel, exp_err);
      end
      step();
      checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== 8'h24 || b_sel_err !== 1'b0) begin
         errors++;
         $display("FAIL sel_in4: got v=%0b d=%0h e=%0b want v=1 d=24 e=0",
                  b_out_valid, b_out_data, b_sel_err);
      end
      step();
   endtask

   task automatic test_reset_midstream();
      a_in_valid = 1'b1;
      a_in_sel   = 3'd4;
      step();
      a_in_sel   = 3'd5;
      step();
      a_in_sel   = 3'd6;
      rst_n      = 1'b0;
      step();
      rst_n      = 1'b1;
      a_in_valid = 1'b0;
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid: got v=%0b rdy=%0b want v=0 rdy=1", a_out_valid, a_in_ready);
      end
      for (int t = 0; t < 5; t++) begin
         step();
         checks++;
         if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush[%0d]: got out_valid=%0b d=%0h want 0", t, a_out_valid,
                     a_out_data);
         end
      end
   endtask

   task automatic test_two_input();
      c_in_valid = 1'b1;
      c_in_sel   = 1'b1;
      step();
      c_in_sel   = 1'b0;
      checks++;
      if (c_out_valid !== 1'b1 || c_out_data !== 1'b1 || c_out_sel !== 1'b1) begin
         errors++;
         $display("FAIL n2_sel1: got v=%0b d=%0b s=%0b want 1 1 1", c_out_valid, c_out_data,
                  c_out_sel);
      end
      step();
      c_in_valid = 1'b0;
      checks++;
      if (c_out_valid !== 1'b1 || c_out_data !== 1'b0 || c_out_sel !== 1'b0) begin
         errors++;
         $display("FAIL n2_sel0: got v=%0b d=%0b s=%0b want 1 0 0", c_out_valid, c_out_data,
                  c_out_sel);
      end
      step();
      checks++;
      if (c_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL n2_idle: got out_valid=%0b want 0", c_out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_sel_check();
      test_reset_midstream();
      test_two_input();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
